// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: next-PC select encodings, reset/bubble constants,
// and the IF/ID payload layout.
package cpu_defs;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned PC_SRC_W = 2;

   typedef enum logic [PC_SRC_W-1:0] {
      PC_SRC_SEQ = 2'b00,
      PC_SRC_BR  = 2'b01,
      PC_SRC_J   = 2'b10,
      PC_SRC_JR  = 2'b11
   } pc_src_e;

   localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;

   // Redirect targets are word addresses; clear the byte offset.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: redirect beats stall, stall beats PC+4.
module pc_next_sel
   import cpu_defs::*;
(
   input  logic [XLEN-1:0]     pc,
   input  logic [PC_SRC_W-1:0] pc_src,
   input  logic                stall,
   input  logic [XLEN-1:0]     branch_target,
   input  logic [XLEN-1:0]     jump_target,
   input  logic [XLEN-1:0]     jr_target,
   output logic [XLEN-1:0]     pc_plus4_c,
   output logic [XLEN-1:0]     pc_next_c
);

   always_comb begin
      pc_plus4_c = pc + XLEN'(4);
      pc_next_c  = pc_plus4_c;
      unique case (pc_src_e'(pc_src))
         PC_SRC_BR:  pc_next_c = word_align(branch_target);
         PC_SRC_J:   pc_next_c = word_align(jump_target);
         PC_SRC_JR:  pc_next_c = word_align(jr_target);
         PC_SRC_SEQ: pc_next_c = stall ? pc : pc_plus4_c;
         default:    pc_next_c = pc_plus4_c;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// count of instructions accepted into IF/ID.
module fetch_stage
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
   parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [1:0]  pc_src,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4_c;
   logic [XLEN-1:0] pc_next_c;
   if_id_t          if_id;

   pc_next_sel u_pc_next_sel (
      .pc            (pc),
      .pc_src        (pc_src),
      .stall         (stall),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .pc_plus4_c    (pc_plus4_c),
      .pc_next_c     (pc_next_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next_c;
      end
   end

   // Flush inserts a bubble even when stalled; stall holds every field.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         if_id <= '{inst: NOP_INST, pc_plus4: '0, valid: 1'b0};
      end else if (!stall) begin
         if_id <= '{inst: imem_inst, pc_plus4: pc_plus4_c, valid: 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (!flush && !stall) begin
         fetch_count <= fetch_count + XLEN'(1);
      end
   end

   assign imem_addr      = pc;
   assign if_id_inst     = if_id.inst;
   assign if_id_pc_plus4 = if_id.pc_plus4;
   assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with a small in-bench instruction ROM.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [1:0]  pc_src;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] jr_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic [31:0] fetch_count;

   int applied    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // ROM: 0x00400000..0x007FFFFF returns addr+0x10000000, else 0.
   assign imem_inst = (imem_addr[31:22] == 10'd1) ? (imem_addr + 32'h1000_0000) : 32'h0;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .pc_src         (pc_src),
      .branch_target  (branch_target),
      .jump_target    (jump_target),
      .jr_target      (jr_target),
      .imem_addr      (imem_addr),
      .imem_inst      (imem_inst),
      .if_id_inst     (if_id_inst),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .fetch_count    (fetch_count)
   );

   typedef struct {
      logic        rst;
      logic        st;
      logic        fl;
      logic [1:0]  src;
      logic [31:0] br;
      logic [31:0] jt;
      logic [31:0] jr;
      logic [31:0] e_addr;
      logic [31:0] e_inst;
      logic [31:0] e_pc4;
      logic        e_valid;
      logic [31:0] e_cnt;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic rst, input logic st, input logic fl,
                               input logic [1:0] src, input logic [31:0] br,
                               input logic [31:0] jt, input logic [31:0] jr,
                               input logic [31:0] ea, input logic [31:0] ei,
                               input logic [31:0] ep, input logic ev,
                               input logic [31:0] ec);
      vec_t v;
      v.rst = rst; v.st = st; v.fl = fl; v.src = src;
      v.br = br; v.jt = jt; v.jr = jr;
      v.e_addr = ea; v.e_inst = ei; v.e_pc4 = ep; v.e_valid = ev; v.e_cnt = ec;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic [31:0] ea, input logic [31:0] ei,
                            input logic [31:0] ep, input logic ev, input logic [31:0] ec);
      check("imem_addr", idx, imem_addr, ea);
      check("if_id_inst", idx, if_id_inst, ei);
      check("if_id_pc_plus4", idx, if_id_pc_plus4, ep);
      check("if_id_valid", idx, {31'b0, if_id_valid}, {31'b0, ev});
      check("fetch_count", idx, fetch_count, ec);
   endtask

   task automatic drive(input logic rst, input logic st, input logic fl, input logic [1:0] src,
                        input logic [31:0] br, input logic [31:0] jt, input logic [31:0] jr);
      reset = rst; stall = st; flush = fl; pc_src = src;
      branch_target = br; jump_target = jt; jr_target = jr;
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);

      //              rst st fl src  br            jt            jr            addr          inst          pc4           v  cnt
      vecs[0]  = mk(1, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0000, 32'h0,        32'h0,        0, 0);
      vecs[1]  = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0004, 32'h1040_0000, 32'h0040_0004, 1, 1);
      vecs[2]  = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0008, 32'h1040_0004, 32'h0040_0008, 1, 2);
      vecs[3]  = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_000C, 32'h1040_0008, 32'h0040_000C, 1, 3);
      vecs[4]  = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0010, 32'h1040_000C, 32'h0040_0010, 1, 4);
      vecs[5]  = mk(0, 1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0010, 32'h1040_000C, 32'h0040_0010, 1, 4);
      vecs[6]  = mk(0, 1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0010, 32'h1040_000C, 32'h0040_0010, 1, 4);
      vecs[7]  = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0014, 32'h1040_0010, 32'h0040_0014, 1, 5);
      vecs[8]  = mk(0, 0, 1, 2'b10, 32'h0,        32'h0040_00D4, 32'h0,        32'h0040_00D4, 32'h0,        32'h0,        0, 5);
      vecs[9]  = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_00D8, 32'h1040_00D4, 32'h0040_00D8, 1, 6);
      vecs[10] = mk(0, 1, 1, 2'b01, 32'h0040_0023, 32'h0,        32'h0,        32'h0040_0020, 32'h0,        32'h0,        0, 6);
      vecs[11] = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0024, 32'h1040_0020, 32'h0040_0024, 1, 7);
      vecs[12] = mk(0, 0, 0, 2'b11, 32'h0,        32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h1040_0024, 32'h0040_0028, 1, 8);
      vecs[13] = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 32'h0,        32'h0000_0000, 1, 9);
      vecs[14] = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 32'h0,        32'h0000_0004, 1, 10);
      vecs[15] = mk(0, 1, 0, 2'b10, 32'h0,        32'h0040_0101, 32'h0,        32'h0040_0100, 32'h0,        32'h0000_0004, 1, 10);
      vecs[16] = mk(1, 1, 1, 2'b11, 32'h0,        32'h0,        32'h0040_0100, 32'h0040_0000, 32'h0,        32'h0,        0, 0);
      vecs[17] = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0004, 32'h1040_0000, 32'h0040_0004, 1, 1);
      vecs[18] = mk(0, 0, 0, 2'b01, 32'h0040_0042, 32'h0,        32'h0,        32'h0040_0040, 32'h1040_0004, 32'h0040_0008, 1, 2);
      vecs[19] = mk(0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0044, 32'h1040_0040, 32'h0040_0044, 1, 3);
      vecs[20] = mk(0, 0, 1, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0040_0048, 32'h0,        32'h0,        0, 3);

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].rst, vecs[i].st, vecs[i].fl, vecs[i].src,
               vecs[i].br, vecs[i].jt, vecs[i].jr);
         @(posedge clk);
         #1;
         applied++;
         check_all(i, vecs[i].e_addr, vecs[i].e_inst, vecs[i].e_pc4,
                   vecs[i].e_valid, vecs[i].e_cnt);
      end

      // Long stall over a bubble: everything holds, then the fetch resumes.
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
         @(posedge clk);
         #1;
         applied++;
         check_all(100 + k, 32'h0040_0048, 32'h0, 32'h0, 1'b0, 32'd3);
      end
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      applied++;
      check_all(104, 32'h0040_004C, 32'h1040_0048, 32'h0040_004C, 1'b1, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000: PC value loaded on reset, the base of the instruction ROM.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000000: the bubble instruction (sll $0,$0,0).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1 bit: load-use hold from hazard unit.
REQ-006 SHALL have port flush, input, 1 bit: squash the IF/ID contents on a taken control transfer.
REQ-007 SHALL have port pc_src, input, 2 bits: next-PC select; 00 = PC+4, 01 = branch, 10 = jump, 11 = jr.
REQ-008 SHALL have port branch_target, input, 32 bits: resolved branch address.
REQ-009 SHALL have port jump_target, input, 32 bits: j/jal address.
REQ-010 SHALL have port jr_target, input, 32 bits: register-indirect jr/jalr address.
REQ-011 SHALL have port imem_addr, output, 32 bits: the current PC, driven to the combinational instruction ROM.
REQ-012 SHALL have port imem_inst, input, 32 bits: ROM data for imem_addr, valid in the same cycle.
REQ-013 SHALL have port if_id_inst, output, 32 bits: registered instruction for ID.
REQ-014 SHALL have port if_id_pc_plus4, output, 32 bits: registered PC+4 of that instruction.
REQ-015 SHALL have port if_id_valid, output, 1 bit: 0 means the IF/ID slot holds a bubble.
REQ-016 SHALL have port fetch_count, output, 32 bits: count of instructions accepted into IF/ID.

Function
REQ-017 SHALL drive imem_addr from the PC register combinationally, with no added latency; an instruction reaches IF/ID exactly 1 cycle after its PC is presented.
REQ-018 SHALL compute PC+4 modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-019 SHALL force bits [1:0] of every selected redirect target to 00 before loading it into the PC.
REQ-020 SHALL update the PC each cycle by this priority: reset > redirect (pc_src != 00; load the selected target) > stall (hold) > PC+4.
REQ-021 SHALL let a redirect override stall; the redirect SHALL still load the PC.
REQ-022 SHALL update IF/ID each cycle by this priority: reset > flush > stall (hold all fields) > load {imem_inst, PC+4, valid=1}.
REQ-023 SHALL, on flush, load if_id_inst=NOP_INST, if_id_valid=0, and if_id_pc_plus4=0; flush SHALL win over a simultaneous stall.
REQ-024 SHALL increment fetch_count only on a non-flush, non-stall IF/ID load, wrapping at 2^32.
REQ-025 SHALL NOT perform any address range check; out-of-range PCs fetch whatever the ROM returns (0 default).

Reset
REQ-026 SHALL, on reset high at a clock edge, set PC=RESET_PC, if_id_inst=NOP_INST, if_id_pc_plus4=0, if_id_valid=0 and fetch_count=0.
REQ-027 SHALL give reset priority over stall, flush and pc_src.
REQ-028 SHALL present imem_addr=RESET_PC in the first cycle after reset deasserts, with a valid fetch on the following edge.
REQ-029 SHALL, when reset is asserted mid-sequence, discard any pending redirect.

Structure
REQ-030 SHALL place the pc_src encodings (PC_SRC_SEQ/BR/J/JR), RESET_PC and NOP_INST in a shared cpu_defs package for reuse by the control unit and hazard unit.
REQ-031 SHALL implement the next-PC selection in one combinational sub-module, pc_next_sel; PC, IF/ID and the counter SHALL be registers in fetch_stage.

Verification
REQ-032 SHALL verify: reset, then 3 free-running cycles -> imem_addr 0x00400000, 0x00400004, 0x00400008; if_id_pc_plus4 = 0x00400004 after the first fetch; fetch_count=2.
REQ-033 SHALL verify: stall=1 for 2 cycles at PC 0x00400010 -> PC and IF/ID unchanged, fetch_count unchanged; resumes at 0x00400014.
REQ-034 SHALL verify: pc_src=10, jump_target=0x004000D4 with flush=1 -> next imem_addr 0x004000D4, if_id_valid=0, if_id_inst=0.
REQ-035 SHALL verify: stall=1, flush=1, pc_src=01, branch_target=0x00400023 together -> PC 0x00400020 and IF/ID bubble.
REQ-036 SHALL verify: PC forced to 0xFFFFFFFC -> next PC 0x00000000.
REQ-037 SHALL verify: reset during pc_src=11 with jr_target=0x00400100 -> PC=0x00400000 and fetch_count=0.
